// File: rtl/countdown_pkg.sv
// countdown_pkg -- shared definitions for the countdown_ctrl block.
//   state_t     : FSM state encoding (IDLE / RUN / DONE)
//   WRAPS_W     : width of the auto-reload wrap counter
//   WRAPS_MAX   : saturation value of the wrap counter
//   wraps_sat_inc : saturating increment helper for the wrap counter
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int WRAPS_W = 8;
  localparam logic [WRAPS_W-1:0] WRAPS_MAX = {WRAPS_W{1'b1}};

  // Wrap count sticks at its maximum instead of rolling over to zero.
  function automatic logic [WRAPS_W-1:0] wraps_sat_inc(input logic [WRAPS_W-1:0] v);
    logic [WRAPS_W-1:0] r;
    if (v == WRAPS_MAX) begin
      r = v;
    end else begin
      r = v + WRAPS_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/countdown_ctrl.sv
// countdown_ctrl -- loadable down-counter with pause, abort, auto-reload and
// a one-cycle completion pulse.
// Ports:
//   COUNTDOWN_Clk       in   clock, rising edge
//   COUNTDOWN_Rst       in   asynchronous active-high reset
//   COUNTDOWN_Start     in   start / restart request
//   COUNTDOWN_Data      in   initial count, captured on an accepted Start
//   COUNTDOWN_En        in   decrement enable (low = pause)
//   COUNTDOWN_Abort     in   cancel a run without Done (only meaningful in RUN)
//   COUNTDOWN_Reload    in   auto-reload mode, sampled at the terminal decrement
//   COUNTDOWN_Threshold in   compare value for Eqn_Flag
//   COUNTDOWN_Out       out  current count (registered)
//   COUNTDOWN_Busy      out  high while in RUN (registered)
//   COUNTDOWN_Done      out  one-cycle completion pulse (registered)
//   COUNTDOWN_Zero_Flag out  Out == 0 (combinational)
//   COUNTDOWN_Eqn_Flag  out  Out == Threshold (combinational)
//   COUNTDOWN_Wraps     out  auto-reloads since last Start, saturating
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int BITWIDTH = 10
) (
  input  logic                COUNTDOWN_Clk,
  input  logic                COUNTDOWN_Rst,
  input  logic                COUNTDOWN_Start,
  input  logic [BITWIDTH-1:0] COUNTDOWN_Data,
  input  logic                COUNTDOWN_En,
  input  logic                COUNTDOWN_Abort,
  input  logic                COUNTDOWN_Reload,
  input  logic [BITWIDTH-1:0] COUNTDOWN_Threshold,
  output logic [BITWIDTH-1:0] COUNTDOWN_Out,
  output logic                COUNTDOWN_Busy,
  output logic                COUNTDOWN_Done,
  output logic                COUNTDOWN_Zero_Flag,
  output logic                COUNTDOWN_Eqn_Flag,
  output logic [WRAPS_W-1:0]  COUNTDOWN_Wraps
);

  localparam logic [BITWIDTH-1:0] CNT_ZERO = {BITWIDTH{1'b0}};
  localparam logic [BITWIDTH-1:0] CNT_ONE  = BITWIDTH'(1);

  state_t                state_q, state_d;
  logic [BITWIDTH-1:0]   out_q, out_d;
  logic [BITWIDTH-1:0]   reload_q, reload_d;
  logic [WRAPS_W-1:0]    wraps_q, wraps_d;
  logic                  done_q;
  logic                  busy_q;
  logic                  wrap_s;
  logic                  take_start_s;

  // Abort outranks Start only while running; elsewhere Abort is ignored.
  assign take_start_s = COUNTDOWN_Start &&
                        ((state_q != ST_RUN) || !COUNTDOWN_Abort);

  // Next-state / next-count decode.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    reload_d = reload_q;
    wraps_d  = wraps_q;
    wrap_s   = 1'b0;
    if (take_start_s) begin
      wraps_d = {WRAPS_W{1'b0}};
      if (COUNTDOWN_Data != CNT_ZERO) begin
        out_d    = COUNTDOWN_Data;
        reload_d = COUNTDOWN_Data;
        state_d  = ST_RUN;
      end else begin
        // Zero-length run completes straight away, skipping RUN.
        out_d   = CNT_ZERO;
        state_d = ST_DONE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (COUNTDOWN_Abort) begin
            out_d   = CNT_ZERO;
            state_d = ST_IDLE;
          end else if (COUNTDOWN_En) begin
            // RUN never holds 0, so the terminal branch also covers any
            // out_q <= 1 and the count can never wrap below zero.
            if (out_q > CNT_ONE) begin
              out_d = out_q - CNT_ONE;
            end else if (COUNTDOWN_Reload) begin
              out_d   = reload_q;
              wraps_d = wraps_sat_inc(wraps_q);
              wrap_s  = 1'b1;
            end else begin
              out_d   = CNT_ZERO;
              state_d = ST_DONE;
            end
          end else begin
            out_d = out_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          out_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // State and registered outputs; Busy/Done are derived from the next state
  // so they line up with the cycle the FSM is actually in.
  always_ff @(posedge COUNTDOWN_Clk or posedge COUNTDOWN_Rst) begin
    if (COUNTDOWN_Rst) begin
      state_q  <= ST_IDLE;
      out_q    <= CNT_ZERO;
      reload_q <= CNT_ZERO;
      wraps_q  <= {WRAPS_W{1'b0}};
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      reload_q <= reload_d;
      wraps_q  <= wraps_d;
      done_q   <= wrap_s || (state_d == ST_DONE);
      busy_q   <= (state_d == ST_RUN);
    end
  end

  assign COUNTDOWN_Out       = out_q;
  assign COUNTDOWN_Busy      = busy_q;
  assign COUNTDOWN_Done      = done_q;
  assign COUNTDOWN_Wraps     = wraps_q;
  assign COUNTDOWN_Zero_Flag = (out_q == CNT_ZERO);
  assign COUNTDOWN_Eqn_Flag  = (out_q == COUNTDOWN_Threshold);

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl -- self-checking bench for countdown_ctrl: directed
// vector table, hand-written multi-cycle sequences, and randomized stimulus
// against a behavioural model.
module tb_countdown_ctrl;
  localparam int BW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, en, abort, reload;
  logic [BW-1:0] data, thr;
  logic [BW-1:0] out;
  logic          busy, done, zf, ef;
  logic [7:0]    wraps;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  bit m_run;
  int m_cnt, m_rel, m_wraps;
  bit m_done;

  typedef struct {
    bit start; int data; bit en; bit abort; bit reload;
    int e_out; bit e_busy; bit e_done; int e_wraps;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  countdown_ctrl #(.BITWIDTH(BW)) dut (
    .COUNTDOWN_Clk(clk), .COUNTDOWN_Rst(rst), .COUNTDOWN_Start(start),
    .COUNTDOWN_Data(data), .COUNTDOWN_En(en), .COUNTDOWN_Abort(abort),
    .COUNTDOWN_Reload(reload), .COUNTDOWN_Threshold(thr),
    .COUNTDOWN_Out(out), .COUNTDOWN_Busy(busy), .COUNTDOWN_Done(done),
    .COUNTDOWN_Zero_Flag(zf), .COUNTDOWN_Eqn_Flag(ef), .COUNTDOWN_Wraps(wraps)
  );

  task automatic check(input string name, input int e_out, input bit e_busy,
                       input bit e_done, input int e_wraps);
    bit e_zf, e_ef;
    e_zf = (e_out == 0);
    e_ef = (e_out == int'(thr));
    n_vec++;
    if (out !== BW'(e_out) || busy !== e_busy || done !== e_done ||
        wraps !== 8'(e_wraps) || zf !== e_zf || ef !== e_ef) begin
      n_err++;
      $display("FAIL %s t=%0t: got out=%0d busy=%0b done=%0b wraps=%0d zero=%0b eqn=%0b; need out=%0d busy=%0b done=%0b wraps=%0d zero=%0b eqn=%0b",
               name, $time, out, busy, done, wraps, zf, ef,
               e_out, e_busy, e_done, e_wraps, e_zf, e_ef);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input int d, input bit e, input bit a, input bit r);
    start = s; data = BW'(d); en = e; abort = a; reload = r;
  endtask

  function automatic vec_t mk(input bit s, input int d, input bit e, input bit a,
                              input bit r, input int o, input bit b, input bit dn,
                              input int w);
    vec_t v;
    v.start = s; v.data = d; v.en = e; v.abort = a; v.reload = r;
    v.e_out = o; v.e_busy = b; v.e_done = dn; v.e_wraps = w;
    return v;
  endfunction

  // Reference behaviour: one clock edge of the countdown described as a
  // running count with a flag saying whether a run is in progress.
  task automatic model_reset();
    m_run = 1'b0; m_cnt = 0; m_rel = 0; m_wraps = 0; m_done = 1'b0;
  endtask

  task automatic model_step(input bit s, input int d, input bit e, input bit a, input bit r);
    m_done = 1'b0;
    if (m_run && a) begin
      m_run = 1'b0;
      m_cnt = 0;
    end else if (s) begin
      m_cnt   = d;
      m_wraps = 0;
      if (d != 0) begin
        m_run = 1'b1;
        m_rel = d;
      end else begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end
    end else if (m_run && e) begin
      if (m_cnt > 1) begin
        m_cnt = m_cnt - 1;
      end else if (r) begin
        m_cnt   = m_rel;
        m_wraps = (m_wraps < 255) ? m_wraps + 1 : 255;
        m_done  = 1'b1;
      end else begin
        m_cnt  = 0;
        m_run  = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; thr = BW'(2);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
    #2;
    check("reset_state", 0, 1'b0, 1'b0, 0);
    tick();
    check("reset_held", 0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- directed vector table ----------------
    // count 5 to completion
    tbl.push_back(mk(1, 5, 1, 0, 0, 5, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 4, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    // zero-length start: Done next cycle, never Busy
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Abort+Start outside RUN: Start wins
    tbl.push_back(mk(1, 2, 0, 1, 0, 2, 1, 0, 0));
    // Abort+Start inside RUN: Abort wins, no Done
    tbl.push_back(mk(1, 9, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    // pause at 2 for three cycles
    tbl.push_back(mk(1, 4, 1, 0, 0, 4, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0));
    // auto-reload of 2, then reload dropped at the terminal step
    tbl.push_back(mk(1, 2, 1, 0, 1, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 2, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 2, 1, 1, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2));
    // restarts: Start beats En, restart with 0, Start during DONE
    tbl.push_back(mk(1, 3, 0, 0, 0, 3, 1, 0, 0));
    tbl.push_back(mk(1, 6, 1, 0, 0, 6, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0));
    // Abort with no Start while running
    tbl.push_back(mk(1, 8, 0, 0, 0, 8, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].start, tbl[i].data, tbl[i].en, tbl[i].abort, tbl[i].reload);
      tick();
      check($sformatf("vec%0d", i), tbl[i].e_out, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_wraps);
    end

    // ---------------- 800-cycle auto-reload, wrap saturation ----------------
    drive(1, 3, 1, 0, 1);
    tick();
    check("reload3_start", 3, 1'b0 | 1'b1, 1'b0, 0);
    drive(0, 0, 1, 0, 1);
    for (int i = 1; i <= 800; i++) begin
      tick();
      check($sformatf("reload3_c%0d", i), 3 - (i % 3), 1'b1, (i % 3) == 0,
            (i / 3 > 255) ? 255 : i / 3);
    end
    drive(1, 0, 0, 0, 0);
    tick();
    check("reload3_restart_clears", 0, 1'b0, 1'b1, 0);
    drive(0, 0, 0, 0, 0);
    tick();

    // ---------------- asynchronous reset mid-run ----------------
    drive(1, 7, 1, 0, 0);
    tick();
    check("rst_run_7", 7, 1'b1, 1'b0, 0);
    drive(0, 0, 1, 0, 0);
    for (int k = 6; k >= 4; k--) begin
      tick();
      check($sformatf("rst_run_%0d", k), k, 1'b1, 1'b0, 0);
    end
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_immediate", 0, 1'b0, 1'b0, 0);
    drive(1, 5, 1, 0, 0);
    tick();
    check("rst_held_ignores_start", 0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 3, 1, 0, 0);
    tick();
    check("rst_resume_3", 3, 1'b1, 1'b0, 0);
    drive(0, 0, 1, 0, 0);
    tick();
    check("rst_resume_2_eqn", 2, 1'b1, 1'b0, 0);
    tick();
    check("rst_resume_1", 1, 1'b1, 1'b0, 0);
    tick();
    check("rst_resume_done", 0, 1'b0, 1'b1, 0);

    // ---------------- randomized against behavioural model ----------------
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    #1;
    model_reset();
    check("rand_reset", m_cnt, m_run, m_done, m_wraps);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit s, e, a, r;
      int d;
      s = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 24) == 0);
      r = $urandom_range(0, 1);
      d = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 6);
      thr = BW'($urandom_range(0, 6));
      drive(s, d, e, a, r);
      model_step(s, d, e, a, r);
      tick();
      check($sformatf("rand%0d", i), m_cnt, m_run, m_done, m_wraps);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 The block SHALL have parameter BITWIDTH, default 10, giving the width of the count, data and threshold buses.
REQ-002 The block SHALL have port COUNTDOWN_Clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port COUNTDOWN_Rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port COUNTDOWN_Start, input, 1, start/restart request, sampled each edge.
REQ-005 The block SHALL have port COUNTDOWN_Data, input, BITWIDTH, initial count, captured on an accepted Start.
REQ-006 The block SHALL have port COUNTDOWN_En, input, 1, decrement enable; low = pause.
REQ-007 The block SHALL have port COUNTDOWN_Abort, input, 1, cancel the run without Done.
REQ-008 The block SHALL have port COUNTDOWN_Reload, input, 1, auto-reload mode, sampled at the terminal decrement.
REQ-009 The block SHALL have port COUNTDOWN_Threshold, input, BITWIDTH, compare value for Eqn_Flag.
REQ-010 The block SHALL have port COUNTDOWN_Out, output, BITWIDTH, current count.
REQ-011 The block SHALL have port COUNTDOWN_Busy, output, 1, high while in RUN.
REQ-012 The block SHALL have port COUNTDOWN_Done, output, 1, one-cycle registered completion pulse.
REQ-013 The block SHALL have port COUNTDOWN_Zero_Flag, output, 1, combinational Out==0.
REQ-014 The block SHALL have port COUNTDOWN_Eqn_Flag, output, 1, combinational Out==Threshold.
REQ-015 The block SHALL have port COUNTDOWN_Wraps, output, 8, count of auto-reloads since last Start, saturating at 255.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 IDLE: Start with Data!=0 SHALL load Out=Data and latch Data as the reload value, clear Wraps and go to RUN at the same edge.
REQ-018 IDLE: Start with Data==0 SHALL set Out=0, clear Wraps and go to DONE (no RUN cycle).
REQ-019 RUN, per edge, priority SHALL be Abort > Start > En; with none asserted, Out SHALL hold.
REQ-020 RUN+Abort SHALL set Out=0 and go to IDLE with no Done pulse.
REQ-021 RUN+Start (no Abort) SHALL restart exactly as REQ-017/REQ-018 with the new Data.
REQ-022 RUN+En with Out>1 SHALL set Out=Out-1.
REQ-023 RUN+En with Out==1 and Reload=0 SHALL set Out=0 and go to DONE.
REQ-024 RUN+En with Out==1 and Reload=1 SHALL set Out=latched reload value, increment Wraps (saturating at 255), assert Done next cycle and stay in RUN.
REQ-025 DONE SHALL last exactly one cycle with Done=1, Busy=0 and Out held, then go to IDLE; a Start in DONE SHALL be accepted as in IDLE.
REQ-026 Latency: Start at edge k with Data=N and En held high SHALL produce Done high during the cycle after edge k+N.
REQ-027 Out SHALL never underflow; decrement from 0 SHALL be impossible by construction.
REQ-028 Abort and Start in IDLE or DONE SHALL resolve as Abort ignored, Start honoured.

Reset
REQ-029 Rst high SHALL immediately force state IDLE, Out=0, reload value=0, Wraps=0, Done=0 and Busy=0, hence Zero_Flag=1.
REQ-030 Reset mid-RUN SHALL discard the run with no Done pulse; operation SHALL resume on the first edge after Rst deasserts.

Structure
REQ-031 FSM state encodings and the Wraps width constant (8) SHALL live in shared package countdown_pkg.
REQ-032 The block SHALL be a single module with no sub-modules; flags SHALL be combinational and all other outputs registered.

Verification
REQ-033 Data=5, Start 1 cycle, En=1 -> Out 5,4,3,2,1,0; Done=1 only in the Out=0 cycle; Busy 1 for 5 cycles then 0.
REQ-034 Data=4, En low for 3 cycles after Out=2 -> Out holds 2 for 3 cycles, then continues; Done 3 cycles later than in REQ-033 timing.
REQ-035 Data=3, Reload=1, En=1 for 800 cycles -> Done every 3rd cycle, Out cycles 3,2,1; Wraps counts up and stays at 255.
REQ-036 Data=6, Abort at Out=3 together with Start -> Out=0, IDLE, no Done; Start with Data=0 -> Done one cycle later, Busy never high.
REQ-037 Data=7, Rst pulsed asynchronously at Out=4 -> all outputs reset without waiting for a clock edge, no Done; Threshold=2 run -> Eqn_Flag high only when Out=2.
